// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: states, opcodes,
// datapath select codes and branch funct3 values.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALRADR
    } state_e;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // R-type and unsupported opcodes have no immediate; they fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller-to-datapath/memory bundle; master is the controller side.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       Lt;
    logic       Ltu;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       Illegal;

    modport master (
        input  op, funct3, Zero, Lt, Ltu, MemReady,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal
    );

    modport slave (
        output op, funct3, Zero, Lt, Ltu, MemReady,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal
    );

endinterface

// File: rtl/multicycle_controller_branch_cond.sv
// Branch-taken evaluation from funct3 and the ALU compare flags.
module branch_cond
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       taken_o,
    output logic       bad_funct3_o
);

    always_comb begin
        taken_o      = 1'b0;
        bad_funct3_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = zero_i;
            F3_BNE:  taken_o = !zero_i;
            F3_BLT:  taken_o = lt_i;
            F3_BGE:  taken_o = !lt_i;
            F3_BLTU: taken_o = ltu_i;
            F3_BGEU: taken_o = !ltu_i;
            default: bad_funct3_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the RV32I multi-cycle datapath with a req/ready
// handshake to the unified memory.
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_controller_if.master ctrl
);

    state_e     state_q, state_d;
    logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
    logic [1:0] resultSrc, srcA, srcB, aluOp;
    logic       taken, badFunct3;

    branch_cond u_branch_cond (
        .funct3_i     (ctrl.funct3),
        .zero_i       (ctrl.Zero),
        .lt_i         (ctrl.Lt),
        .ltu_i        (ctrl.Ltu),
        .taken_o      (taken),
        .bad_funct3_o (badFunct3)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        memReq    = 1'b0;
        memWrite  = 1'b0;
        adrSrc    = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        illegal   = 1'b0;
        resultSrc = RES_ALUOUT;
        srcA      = SRCA_PC;
        srcB      = SRCB_RS2;
        aluOp     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                memReq    = 1'b1;
                srcB      = SRCB_FOUR;
                resultSrc = RES_ALURESULT;
                if (ctrl.MemReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                srcA = SRCA_OLDPC;
                srcB = SRCB_IMM;
                case (ctrl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALRADR;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                srcA    = SRCA_RS1;
                srcB    = SRCB_IMM;
                state_d = (ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (ctrl.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc = RES_DATA;
                regWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
                if (ctrl.MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                srcA    = SRCA_RS1;
                srcB    = SRCB_RS2;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                srcA    = SRCA_RS1;
                srcB    = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                srcA    = SRCA_RS1;
                srcB    = SRCB_RS2;
                aluOp   = ALUOP_BRANCH;
                pcWrite = taken;
                illegal = badFunct3;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link.
                srcA    = SRCA_OLDPC;
                srcB    = SRCB_FOUR;
                pcWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALRADR: begin
                srcA    = SRCA_RS1;
                srcB    = SRCB_IMM;
                state_d = S_JAL;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // While held in reset, strobes are suppressed and selects show FETCH values.
    assign ctrl.MemReq    = reset_n & memReq;
    assign ctrl.MemWrite  = reset_n & memWrite;
    assign ctrl.AdrSrc    = reset_n & adrSrc;
    assign ctrl.IRWrite   = reset_n & irWrite;
    assign ctrl.PCWrite   = reset_n & pcWrite;
    assign ctrl.RegWrite  = reset_n & regWrite;
    assign ctrl.Illegal   = reset_n & illegal;
    assign ctrl.ResultSrc = reset_n ? resultSrc : RES_ALURESULT;
    assign ctrl.ALUSrcA   = reset_n ? srcA : SRCA_PC;
    assign ctrl.ALUSrcB   = reset_n ? srcB : SRCB_FOUR;
    assign ctrl.ALUOp     = reset_n ? aluOp : ALUOP_ADD;
    assign ctrl.ImmSrc    = imm_src_of(ctrl.op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for multicycle_controller; every output is
// packed into one vector and compared against hand-derived expectations.
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LUI  = 7'b0110111;

    logic clk = 1'b0;
    logic reset_n;
    int   checkCount = 0;
    int   passCount  = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    always #5 clk = ~clk;

    // {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
    //  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal}
    logic [16:0] observed;
    assign observed = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite,
                       bus.PCWrite, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA,
                       bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.Illegal};

    function automatic logic [16:0] expVec(
        input logic mreq, input logic mwr, input logic adr, input logic irw,
        input logic pcw, input logic rw, input logic [1:0] res,
        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop,
        input logic [1:0] imm, input logic ill);
        return {mreq, mwr, adr, irw, pcw, rw, res, sa, sb, aop, imm, ill};
    endfunction

    function automatic logic [16:0] fetchWait(input logic [1:0] imm);
        return expVec(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
    endfunction

    function automatic logic [16:0] fetchDone(input logic [1:0] imm);
        return expVec(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
    endfunction

    function automatic logic [16:0] decodeVec(input logic [1:0] imm, input logic ill);
        return expVec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, ill);
    endfunction

    function automatic logic [16:0] aluWb(input logic [1:0] imm);
        return expVec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic zero, input logic lt,
                                 input logic ltu, input logic ready);
        bus.op       = op;
        bus.funct3   = f3;
        bus.Zero     = zero;
        bus.Lt       = lt;
        bus.Ltu      = ltu;
        bus.MemReady = ready;
    endtask

    task automatic stepCycle(input string tag, input logic [16:0] want);
        @(negedge clk);
        checkOutput(tag, {15'b0, observed}, {15'b0, want});
        @(posedge clk);
        #1;
    endtask

    task automatic runBranch(input string tag, input logic [2:0] f3,
                             input logic zero, input logic lt, input logic ltu,
                             input logic pcw, input logic ill);
        applyStimulus(BR, f3, zero, lt, ltu, 1'b1);
        stepCycle({tag, " fetch"}, fetchDone(2'b10));
        stepCycle({tag, " decode"}, decodeVec(2'b10, 1'b0));
        stepCycle({tag, " branch"},
                  expVec(0, 0, 0, 0, pcw, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, ill));
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(7'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        stepCycle("in reset", expVec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 0));
        reset_n = 1'b1;

        applyStimulus(RTY, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("R fetch", fetchDone(2'b00));
        stepCycle("R decode", decodeVec(2'b00, 1'b0));
        stepCycle("R execr", expVec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0));
        stepCycle("R aluwb", aluWb(2'b00));

        applyStimulus(LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle("lw fetch wait1", fetchWait(2'b00));
        stepCycle("lw fetch wait2", fetchWait(2'b00));
        bus.MemReady = 1'b1;
        stepCycle("lw fetch", fetchDone(2'b00));
        stepCycle("lw decode", decodeVec(2'b00, 1'b0));
        stepCycle("lw memadr", expVec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        bus.MemReady = 1'b0;
        stepCycle("lw memread wait1", expVec(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        stepCycle("lw memread wait2", expVec(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        bus.MemReady = 1'b1;
        stepCycle("lw memread", expVec(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        stepCycle("lw memwb", expVec(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        applyStimulus(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("sw fetch", fetchDone(2'b01));
        stepCycle("sw decode", decodeVec(2'b01, 1'b0));
        stepCycle("sw memadr", expVec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0));
        stepCycle("sw memwrite", expVec(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0));

        runBranch("bne nz", 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runBranch("beq nz", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runBranch("beq z", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        runBranch("blt lt", 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        runBranch("bge lt", 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runBranch("bltu ltu", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        runBranch("bgeu nltu", 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        runBranch("bad f3", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        applyStimulus(JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("jal fetch", fetchDone(2'b11));
        stepCycle("jal decode", decodeVec(2'b11, 1'b0));
        stepCycle("jal jal", expVec(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 0));
        stepCycle("jal aluwb", aluWb(2'b11));

        applyStimulus(JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("jalr fetch", fetchDone(2'b00));
        stepCycle("jalr decode", decodeVec(2'b00, 1'b0));
        stepCycle("jalr adr", expVec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        stepCycle("jalr jal", expVec(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        stepCycle("jalr aluwb", aluWb(2'b00));

        applyStimulus(ITY, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("I fetch", fetchDone(2'b00));
        stepCycle("I decode", decodeVec(2'b00, 1'b0));
        stepCycle("I execi", expVec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0));
        stepCycle("I aluwb", aluWb(2'b00));

        applyStimulus(LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("lui fetch", fetchDone(2'b00));
        stepCycle("lui decode", decodeVec(2'b00, 1'b1));
        bus.MemReady = 1'b0;
        stepCycle("lui back to fetch", fetchWait(2'b00));

        applyStimulus(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle("abort sw fetch", fetchDone(2'b01));
        stepCycle("abort sw decode", decodeVec(2'b01, 1'b0));
        stepCycle("abort sw memadr", expVec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 0));
        bus.MemReady = 1'b0;
        stepCycle("abort sw wait1", expVec(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0));
        stepCycle("abort sw wait2", expVec(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0));
        reset_n      = 1'b0;
        bus.MemReady = 1'b1;
        stepCycle("abort sw in reset", expVec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 0));
        reset_n      = 1'b1;
        bus.MemReady = 1'b0;
        stepCycle("after abort fetch wait", fetchWait(2'b01));
        bus.MemReady = 1'b1;
        stepCycle("after abort fetch", fetchDone(2'b01));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the RV32I multi-cycle datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, register-file, PC/IR and memory enables each cycle. It also holds a request/ready handshake to the unified instruction/data memory, inserting wait states until memory responds. It sits beside the existing ALU decoder, which consumes ALUOp; immediate generation, the ALU and the registers live in the datapath.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12] from IR
- Zero  in  1  ALU result == 0
- Lt  in  1  signed SrcA < SrcB
- Ltu  in  1  unsigned SrcA < SrcB
- MemReady  in  1  memory completes the current access this cycle
- MemReq  out  1  memory access active
- MemWrite  out  1  store, qualified by MemReq
- AdrSrc  out  1  0: PC, 1: ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  write rd
- ResultSrc  out  2  00: ALUOut, 01: Data, 10: ALUResult
- ALUSrcA  out  2  00: PC, 01: OldPC, 10: A (rs1)
- ALUSrcB  out  2  00: B (rs2), 01: ImmExt, 10: constant 4
- ALUOp  out  2  00: add, 01: branch compare/subtract, 10: funct-decoded
- ImmSrc  out  2  00: I, 01: S, 10: B, 11: J; combinational from op
- Illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, B 1100011, jal 1101111, jalr 1100111.
- Unlisted outputs in each state are 0, and selects are 00.
- FETCH: MemReq, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - Stays in FETCH until MemReady.
  - IRWrite and PCWrite assert only in the MemReady cycle; then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, so ALUOut = OldPC+imm. Next state by op:
  - lw/sw → MEMADR; R → EXECR; I → EXECI; B → BRANCH; jal → JAL; jalr → JALRADR.
  - Any other opcode → Illegal=1, next state FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemReq, AdrSrc=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite. Next is FETCH.
- MEMWRITE: MemReq, MemWrite, AdrSrc=1. Waits for MemReady, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite. Next is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite = taken. Next is FETCH.
  - taken by funct3: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu.
  - funct3 010/011 → taken=0 and Illegal=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite. This loads PC from ALUOut and computes OldPC+4. Next is ALUWB.
- JALRADR: ALUSrcA=10, ALUSrcB=01, so ALUOut = rs1+imm. Next is JAL.
- The datapath clears bit 0 of the jalr target. The controller does not touch it.

## Timing
- State register only; outputs are combinational decode of state and the IR fields (Moore, except the MemReady qualification and branch taken).
- Cycle counts with MemReady held at 1:
  - B: 3 cycles.
  - R, I, sw, jal: 4 cycles.
  - lw, jalr: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- MemReq, MemWrite and the address select stay stable until the MemReady cycle. MemReady is ignored while MemReq=0.
- Reset (reset_n=0 at an edge): next state is FETCH, from any state, including mid-wait.
  - While reset_n=0, MemReq, MemWrite, IRWrite, PCWrite, RegWrite and Illegal are forced to 0.
  - Select outputs take their FETCH values.
  - An aborted store or load never completes.
- Illegal opcode: PC has already advanced in FETCH. No register or memory write occurs.

## Structure
- Shared package rv_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - ResultSrc, ALUSrcA, ALUSrcB and ALUOp encodings;
  - branch funct3 constants.
- ImmSrc decode lives here; maindec is not instantiated.
- One sub-module, branch_cond: combinational, taking funct3, Zero, Lt and Ltu and producing taken and bad_funct3.

## Test plan
- R-type add with MemReady=1 → states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4. IRWrite and PCWrite only in cycle 1.
- lw with MemReady low for 2 cycles in both FETCH and MEMREAD → 9 cycles total. MemReq held steady with AdrSrc=1 in MEMREAD. RegWrite only in MEMWB.
- bne with Zero=0 → PCWrite=1 in BRANCH. beq with Zero=0 → PCWrite=0. funct3=010 → Illegal=1 and no PCWrite.
- jalr → states FETCH, DECODE, JALRADR, JAL, ALUWB. PCWrite in FETCH and JAL; RegWrite in ALUWB only.
- op=0110111 (lui) → Illegal pulses 1 cycle in DECODE, next FETCH. No RegWrite, no MemWrite.
- reset_n=0 during a MEMWRITE wait → MemReq and MemWrite drop immediately. FETCH in the next cycle after release. No write is seen.
